// File: rtl/dma_bus_arbiter_if.sv
// Requester and memory-command signal bundle for dma_bus_arbiter.
// master = arbiter side, slave = requesters plus memory controller.
interface dma_bus_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int ADDR_WIDTH = 28,
  parameter int LEN_WIDTH  = 4
);
  localparam int OWNER_WIDTH = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [REQUESTERS-1:0]            Req;
  logic [REQUESTERS*ADDR_WIDTH-1:0] ReqAddr;
  logic [REQUESTERS-1:0]            ReqWrite;
  logic [REQUESTERS*LEN_WIDTH-1:0]  ReqLen;
  logic [REQUESTERS-1:0]            Grant;
  logic [OWNER_WIDTH-1:0]           Owner;
  logic                             Busy;
  logic                             MemValid;
  logic                             MemReady;
  logic [ADDR_WIDTH-1:0]            MemAddr;
  logic                             MemWrite;
  logic [LEN_WIDTH-1:0]             MemLen;
  logic                             MemBeat;

  modport master (
    input  Req, ReqAddr, ReqWrite, ReqLen, MemReady, MemBeat,
    output Grant, Owner, Busy, MemValid, MemAddr, MemWrite, MemLen
  );

  modport slave (
    output Req, ReqAddr, ReqWrite, ReqLen, MemReady, MemBeat,
    input  Grant, Owner, Busy, MemValid, MemAddr, MemWrite, MemLen
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Burst-level arbiter for the shared DDR command port: priority port 0 with
// anti-starvation limit, round-robin over ports 1..N-1, ownership held per burst.
module dma_bus_arbiter #(
  parameter int REQUESTERS   = 4,
  parameter int ADDR_WIDTH   = 28,
  parameter int LEN_WIDTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  dma_bus_arbiter_if.master  bus
);
  localparam int unsigned N  = REQUESTERS;
  localparam int          OW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int          SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

  state_t                state, state_next;
  logic [OW-1:0]         owner, rr_ptr, rr_idx, win_idx;
  logic [SW-1:0]         starve_cnt;
  logic [LEN_WIDTH-1:0]  beat_cnt, mem_len, sel_len;
  logic [ADDR_WIDTH-1:0] mem_addr, sel_addr;
  logic                  mem_valid, mem_write, busy, sel_write;
  logic                  any_req, others_req, rr_found, port0_wins;
  logic                  accept, beat_in_burst, last_beat;
  int unsigned           cand;

  assign any_req       = |bus.Req;
  assign others_req    = |bus.Req[REQUESTERS-1:1];
  assign accept        = (state == ISSUE) && mem_valid && bus.MemReady;
  assign beat_in_burst = (state == BURST) && bus.MemBeat;
  assign last_beat     = beat_in_burst && (beat_cnt == '0);

  // Round-robin search over ports 1..N-1 beginning at rr_ptr, wrapping N-1 -> 1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand > N - 1) cand = cand - (N - 1);
      if (!rr_found && |(bus.Req & (REQUESTERS'(1) << cand))) begin
        rr_found = 1'b1;
        rr_idx   = OW'(cand);
      end
    end
  end

  // Port 0 also wins when it is the only requester, regardless of the counter.
  assign port0_wins = bus.Req[0] && ((starve_cnt < SW'(STARVE_LIMIT)) || !rr_found);
  assign win_idx    = port0_wins ? '0 : rr_idx;

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_len   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (OW'(i) == win_idx) begin
        sel_addr  = bus.ReqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_write = bus.ReqWrite[i];
        sel_len   = bus.ReqLen[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)   state_next = ISSUE;
      ISSUE:   if (accept)    state_next = BURST;
      BURST:   if (last_beat) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      owner      <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_len    <= '0;
      busy       <= 1'b0;
      beat_cnt   <= '0;
      rr_ptr     <= OW'(1);
      starve_cnt <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= win_idx;
        mem_addr  <= sel_addr;
        mem_write <= sel_write;
        mem_len   <= sel_len;
        mem_valid <= 1'b1;
        if (win_idx == '0) begin
          if (!others_req)                          starve_cnt <= '0;
          else if (starve_cnt < SW'(STARVE_LIMIT))  starve_cnt <= starve_cnt + 1'b1;
        end else begin
          starve_cnt <= '0;
          rr_ptr     <= (win_idx == OW'(N - 1)) ? OW'(1) : win_idx + 1'b1;
        end
      end
      if (accept) begin
        mem_valid <= 1'b0;
        busy      <= 1'b1;
        beat_cnt  <= mem_len;
      end
      if (beat_in_burst) begin
        if (beat_cnt == '0) busy     <= 1'b0;
        else                beat_cnt <= beat_cnt - 1'b1;
      end
    end
  end

  assign bus.Grant    = accept ? (REQUESTERS'(1) << owner) : '0;
  assign bus.Owner    = owner;
  assign bus.Busy     = busy;
  assign bus.MemValid = mem_valid;
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWrite = mem_write;
  assign bus.MemLen   = mem_len;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter: expected commands are queued as requests
// are driven and popped when a Grant appears; a memory model returns beats while Busy.
module tb_dma_bus_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 28;
  localparam int LW   = 4;

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    logic        wr;
    logic [LW-1:0] len;
  } exp_t;

  logic Clk, Reset_n;
  logic bfm_beat, stray_beat;
  exp_t sb[$];
  int   n_checks, n_fail;
  int   bursts_done, grants_seen, beats_driven;

  dma_bus_arbiter_if #(.REQUESTERS(NREQ), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  dma_bus_arbiter #(
    .REQUESTERS(NREQ), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STARVE_LIMIT(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus.master)
  );

  assign bus.MemBeat = bfm_beat | stray_beat;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic w, input logic [LW-1:0] l);
    bus.ReqAddr[p*AW +: AW] = a;
    bus.ReqWrite[p]         = w;
    bus.ReqLen[p*LW +: LW]  = l;
  endtask

  task automatic expect_cmd(input int p, input logic [AW-1:0] a, input logic w, input logic [LW-1:0] l);
    exp_t e;
    e.port = p; e.addr = a; e.wr = w; e.len = l;
    sb.push_back(e);
  endtask

  task automatic wait_bursts(input int n, input string tag);
    int  target;
    time deadline;
    target   = bursts_done + n;
    deadline = $time + 3000;
    while (bursts_done < target && $time < deadline) @(bursts_done or posedge Clk);
    check(tag, bursts_done, target);
  endtask

  task automatic wait_grants(input int n, input string tag);
    int  target;
    time deadline;
    target   = grants_seen + n;
    deadline = $time + 1000;
    while (grants_seen < target && $time < deadline) @(grants_seen or posedge Clk);
    check(tag, grants_seen, target);
  endtask

  task automatic wait_beats(input int n, input string tag);
    time deadline;
    deadline = $time + 1000;
    while (beats_driven < n && $time < deadline) @(beats_driven or posedge Clk);
    check(tag, beats_driven, n);
  endtask

  // Memory-controller model and grant monitor: checks each command against the
  // scoreboard, then returns beats for as long as Busy stays high.
  initial begin
    int   cnt, exp_beats;
    bit   active;
    exp_t e;
    bfm_beat = 1'b0; active = 0; cnt = 0; exp_beats = 0;
    bursts_done = 0; grants_seen = 0; beats_driven = 0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        active   = 0;
        bfm_beat = 1'b0;
      end else begin
        if (active) begin
          if (bus.Busy && cnt < 40) begin
            bfm_beat = 1'b1;
            cnt++;
            beats_driven = cnt;
          end else begin
            bfm_beat = 1'b0;
            check("burst_beats", cnt, exp_beats);
            active = 0;
            bursts_done++;
          end
        end
        if (bus.Grant != '0) begin
          if (sb.size() == 0) begin
            check("grant_unexpected", bus.Grant, 0);
            exp_beats = 0;
          end else begin
            e = sb.pop_front();
            check("grant_onehot", bus.Grant, 64'(1) << e.port);
            check("grant_owner", bus.Owner, e.port);
            check("grant_addr", bus.MemAddr, e.addr);
            check("grant_write", bus.MemWrite, e.wr);
            check("grant_len", bus.MemLen, e.len);
            exp_beats = int'(e.len) + 1;
          end
          active       = 1;
          cnt          = 0;
          beats_driven = 0;
          bfm_beat     = 1'b0;
          grants_seen++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    Reset_n = 1'b1; stray_beat = 1'b0;
    bus.Req = '0; bus.ReqAddr = '0; bus.ReqWrite = '0; bus.ReqLen = '0;
    bus.MemReady = 1'b1;

    #2 Reset_n = 1'b0;
    #1;
    check("rst_grant", bus.Grant, 0);
    check("rst_owner", bus.Owner, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_valid", bus.MemValid, 0);
    check("rst_addr", bus.MemAddr, 0);
    check("rst_write", bus.MemWrite, 0);
    check("rst_len", bus.MemLen, 0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Round-robin over ports 1..3 from the reset pointer.
    @(posedge Clk); #1;
    for (int p = 1; p < 4; p++) set_port(p, 28'h0100000 + 28'(p * 16), (p == 3), 4'd0);
    for (int r = 0; r < 2; r++)
      for (int p = 1; p < 4; p++) expect_cmd(p, 28'h0100000 + 28'(p * 16), (p == 3), 4'd0);
    bus.Req = 4'b1110;
    wait_bursts(6, "rr_bursts");
    bus.Req = '0;

    // Single request, 4-beat burst.
    @(posedge Clk); #1;
    set_port(2, 28'h0001000, 1'b0, 4'd3);
    expect_cmd(2, 28'h0001000, 1'b0, 4'd3);
    bus.Req = 4'b0100;
    @(negedge Clk);
    check("single_valid_idle", bus.MemValid, 0);
    @(negedge Clk);
    check("single_valid", bus.MemValid, 1);
    check("single_addr", bus.MemAddr, 28'h0001000);
    check("single_len", bus.MemLen, 3);
    @(posedge Clk); #1 bus.Req = '0;
    wait_bursts(1, "single_burst");

    // Priority port with starvation limit against port 3.
    @(posedge Clk); #1;
    set_port(0, 28'h0000200, 1'b1, 4'd0);
    set_port(3, 28'h0003300, 1'b0, 4'd0);
    for (int k = 0; k < 8; k++) expect_cmd(0, 28'h0000200, 1'b1, 4'd0);
    expect_cmd(3, 28'h0003300, 1'b0, 4'd0);
    expect_cmd(0, 28'h0000200, 1'b1, 4'd0);
    bus.Req = 4'b1001;
    wait_bursts(10, "starve_bursts");
    bus.Req = '0;

    // Backpressure: command must hold while MemReady is low.
    @(posedge Clk); #1;
    bus.MemReady = 1'b0;
    set_port(1, 28'h0ABCDE0, 1'b1, 4'd1);
    expect_cmd(1, 28'h0ABCDE0, 1'b1, 4'd1);
    bus.Req = 4'b0010;
    @(posedge Clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check("bp_valid", bus.MemValid, 1);
      check("bp_addr", bus.MemAddr, 28'h0ABCDE0);
      check("bp_write", bus.MemWrite, 1);
      check("bp_len", bus.MemLen, 1);
      check("bp_owner", bus.Owner, 1);
      check("bp_grant", bus.Grant, 0);
      @(posedge Clk); #1;
      if (k == 0) begin
        set_port(1, 28'h0FFFFF0, 1'b0, 4'd7);
        set_port(3, 28'h0123450, 1'b1, 4'd2);
        bus.Req = 4'b1010;
      end
      if (k == 2) bus.Req = 4'b1000;
    end
    bus.Req = '0;
    bus.MemReady = 1'b1;
    wait_bursts(1, "bp_burst");

    // Stray beats in IDLE and on the accept cycle.
    @(posedge Clk); #1 stray_beat = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("stray_idle_busy", bus.Busy, 0);
      check("stray_idle_valid", bus.MemValid, 0);
    end
    @(posedge Clk); #1;
    stray_beat = 1'b0;
    set_port(2, 28'h0000ABC, 1'b0, 4'd1);
    expect_cmd(2, 28'h0000ABC, 1'b0, 4'd1);
    bus.Req = 4'b0100;
    @(posedge Clk); #1 stray_beat = 1'b1;
    @(posedge Clk); #1 begin stray_beat = 1'b0; bus.Req = '0; end
    wait_bursts(1, "stray_burst");

    // Reset during a burst; pending requests re-arbitrate from pointer 1.
    @(posedge Clk); #1;
    set_port(1, 28'h0300000, 1'b1, 4'd3);
    expect_cmd(1, 28'h0300000, 1'b1, 4'd3);
    bus.Req = 4'b0010;
    wait_grants(1, "rst_mid_grant");
    bus.Req = 4'b1010;
    wait_beats(2, "rst_mid_beats");
    @(posedge Clk); #2 Reset_n = 1'b0;
    #1;
    check("rmid_grant", bus.Grant, 0);
    check("rmid_owner", bus.Owner, 0);
    check("rmid_busy", bus.Busy, 0);
    check("rmid_valid", bus.MemValid, 0);
    check("rmid_addr", bus.MemAddr, 0);
    check("rmid_write", bus.MemWrite, 0);
    check("rmid_len", bus.MemLen, 0);
    expect_cmd(1, 28'h0300000, 1'b1, 4'd3);
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;
    wait_grants(1, "rearb_grant");
    bus.Req = '0;
    wait_bursts(1, "rearb_burst");

    repeat (3) @(posedge Clk);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end
endmodule
